// File: rtl/risp_synapse_array.sv
// risp_synapse_array: run-time configurable bank of RISP synapses feeding one neuron.
// Each synapse delays its spike by a programmable count of timesteps; arrivals are summed and saturated.
module risp_synapse_array #(
  parameter int NUM_SYN = 4,
  parameter int MAX_DELAY = 15,
  parameter int WEIGHT_WIDTH = 8,
  parameter int CHARGE_WIDTH = 8,
  parameter int FIRE_LIKE_RAVENS = 0,
  localparam int IW = NUM_SYN > 1 ? $clog2(NUM_SYN) : 1,
  localparam int DW = $clog2(MAX_DELAY + 1)
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           en,
  input  logic [NUM_SYN-1:0]             inp,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [IW-1:0]                  cfg_idx,
  input  logic signed [WEIGHT_WIDTH-1:0] cfg_weight,
  input  logic [DW-1:0]                  cfg_delay,
  output logic                           cfg_err,
  output logic signed [CHARGE_WIDTH-1:0] out,
  output logic                           out_sat
);
  localparam int SW = CHARGE_WIDTH + $clog2(NUM_SYN) + 1;
  localparam logic signed [SW-1:0] HI = SW'((2 ** (CHARGE_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] LO = ~HI;
  logic signed [WEIGHT_WIDTH-1:0] w [NUM_SYN];
  logic [DW-1:0] d [NUM_SYN];
  logic [MAX_DELAY:1] l [NUM_SYN];
  logic [NUM_SYN-1:0] tap;
  logic signed [SW-1:0] sum;
  logic ok, acc, rej, err;
  assign ok = (int'(cfg_idx) < NUM_SYN) && (int'(cfg_delay) <= MAX_DELAY) && (int'(cfg_delay) >= FIRE_LIKE_RAVENS);
  assign cfg_ready = ~en;
  assign acc = cfg_valid & cfg_ready & ok;
  assign rej = cfg_valid & cfg_ready & ~ok;
  assign cfg_err = err;
  // Bit 0 of {line, inp} is the zero-delay path, bit k is the spike k timesteps old.
  always_comb begin
    tap = '0;
    sum = '0;
    for (int i = 0; i < NUM_SYN; i++) begin
      tap[i] = 1'({l[i], inp[i]} >> (d[i] - DW'(FIRE_LIKE_RAVENS)));
      sum = sum + (tap[i] ? SW'(w[i]) : '0);
    end
  end
  assign out_sat = (sum > HI) || (sum < LO);
  assign out = sum > HI ? HI[CHARGE_WIDTH-1:0] : sum < LO ? LO[CHARGE_WIDTH-1:0] : sum[CHARGE_WIDTH-1:0];
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      err <= 1'b0;
      for (int i = 0; i < NUM_SYN; i++) begin
        w[i] <= '0;
        d[i] <= DW'(FIRE_LIKE_RAVENS);
        l[i] <= '0;
      end
    end else begin
      err <= rej;
      for (int i = 0; i < NUM_SYN; i++) begin
        if (acc && int'(cfg_idx) == i) begin
          w[i] <= cfg_weight;
          d[i] <= cfg_delay;
          l[i] <= '0;
        end else if (en) begin
          l[i] <= MAX_DELAY'({l[i], inp[i]});
        end
      end
    end
  end
endmodule
